prog_mod_counter: RTL

- Parametrised successor to the fixed mod-N up/down counter.
- Features:
  - runtime-programmable modulus
  - synchronous load
  - count enable
  - wrap or saturate mode
  - registered wrap/saturation event pulses
  - saturating wrap tally
  - error flag for illegal writes
- Used as a general-purpose cyclic index/timer in datapath and sequencing blocks.

---
 rtl/prog_mod_counter.sv | 102 ++++++++++
 1 files changed

// File: rtl/prog_mod_counter.sv
// prog_mod_counter
//   Cyclic up/down counter whose modulus can be changed at run time.
//   Wraps or saturates at the ends of the range, and keeps a saturating
//   count of wraps. Each edge performs at most one action, in priority
//   order: reset > modulus write > load > count step.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   en        count enable
//   up_down   1 = count up, 0 = count down
//   sat_mode  0 = wrap at the range ends, 1 = hold at the range ends
//   load      load strobe; load_val must be below mod_q
//   load_val  value to load
//   mod_wr    modulus write strobe; mod_val must be non-zero
//   mod_val   new modulus
//   count     current count, always in 0..mod_q-1
//   mod_q     active modulus
//   wrap      pulse: the previous edge wrapped the count
//   sat_hit   pulse: the previous edge blocked a step at a range end
//   err       pulse: the previous edge rejected a load or modulus write
//   wrap_cnt  wraps since reset, holds at all-ones

module prog_mod_counter #(
    parameter int W           = 4,
    parameter int DEFAULT_MOD = 10,
    parameter int WC          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          up_down,
    input  logic          sat_mode,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          mod_wr,
    input  logic [W-1:0]  mod_val,
    output logic [W-1:0]  count,
    output logic [W-1:0]  mod_q,
    output logic          wrap,
    output logic          sat_hit,
    output logic          err,
    output logic [WC-1:0] wrap_cnt
);

    localparam logic [W-1:0] MOD_RST = W'(DEFAULT_MOD);

    // mod_q never drops to zero, so this cannot underflow.
    logic [W-1:0] count_max;
    logic         at_top;
    logic         at_bottom;

    assign count_max = mod_q - 1'b1;
    assign at_top    = (count == count_max);
    assign at_bottom = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            mod_q    <= MOD_RST;
            wrap     <= 1'b0;
            sat_hit  <= 1'b0;
            err      <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
            err     <= 1'b0;

            if (mod_wr) begin
                if (mod_val == '0) begin
                    err <= 1'b1;
                end else begin
                    mod_q <= mod_val;
                    // Pull the count back into range when the modulus shrinks below it.
                    if (count >= mod_val)
                        count <= '0;
                end
            end else if (load) begin
                if (load_val < mod_q)
                    count <= load_val;
                else
                    err <= 1'b1;
            end else if (en) begin
                // With mod_q = 1 both at_top and at_bottom are true, so every step is a boundary.
                if (up_down ? at_top : at_bottom) begin
                    if (sat_mode) begin
                        sat_hit <= 1'b1;
                    end else begin
                        count <= up_down ? '0 : count_max;
                        wrap  <= 1'b1;
                        if (wrap_cnt != '1)
                            wrap_cnt <= wrap_cnt + 1'b1;
                    end
                end else begin
                    count <= up_down ? count + 1'b1 : count - 1'b1;
                end
            end
        end
    end

endmodule
